// File: rtl/burst_line_buffer.sv
// Collects one cache-line refill burst (optionally wrapped, critical-word-first)
// into a full line, forwards the first beat early and hands the line off with valid/ready.
module burst_line_buffer #(
  parameter  int BEAT_W = 32,
  parameter  int LINE_W = 512,
  localparam int BEATS  = LINE_W / BEAT_W,
  localparam int IDX_W  = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              start,
  input  logic [IDX_W-1:0]  start_idx,
  input  logic [BEAT_W-1:0] beat_data,
  input  logic              beat_valid,
  input  logic              beat_last,
  output logic              beat_ready,
  output logic              crit_valid,
  output logic [BEAT_W-1:0] crit_data,
  output logic [LINE_W-1:0] line_data,
  output logic              line_valid,
  input  logic              line_ready,
  output logic              busy,
  output logic              last_err
);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  ptr_reg;
  logic [IDX_W-1:0]  cnt_reg;
  logic [BEAT_W-1:0] crit_data_reg;
  logic              crit_valid_reg;
  logic              last_err_reg;
  logic [BEAT_W-1:0] slot_reg [BEATS];

  logic accept;
  logic load;
  logic clear_buf;
  logic cnt_is_last;

  // flush suppresses acceptance even though beat_ready still follows the state
  assign accept      = (state_reg == FILL) && beat_valid && !flush;
  assign load        = !flush && start &&
                       ((state_reg == IDLE) || ((state_reg == HOLD) && line_ready));
  assign clear_buf   = flush || load;
  assign cnt_is_last = (cnt_reg == IDX_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (start) state_next = FILL;
        FILL: if (accept && cnt_is_last) state_next = HOLD;
        HOLD: if (line_ready) state_next = start ? FILL : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    beat_ready = 1'b0;
    line_valid = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      FILL: begin
        beat_ready = 1'b1;
        busy       = 1'b1;
      end
      HOLD: begin
        line_valid = 1'b1;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg        <= '0;
      cnt_reg        <= '0;
      crit_data_reg  <= '0;
      crit_valid_reg <= 1'b0;
      last_err_reg   <= 1'b0;
    end else begin
      crit_valid_reg <= accept && (cnt_reg == '0);
      last_err_reg   <= accept && (beat_last != cnt_is_last);
      if (load) begin
        ptr_reg <= start_idx;
      end else if (accept) begin
        ptr_reg <= ptr_reg + 1'b1;
      end
      if (clear_buf) begin
        cnt_reg <= '0;
      end else if (accept) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (flush) begin
        crit_data_reg <= '0;
      end else if (accept && (cnt_reg == '0)) begin
        crit_data_reg <= beat_data;
      end
    end
  end

  // One register slot per beat position; the write pointer wraps naturally.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (rst || clear_buf) begin
          slot_reg[gi] <= '0;
        end else if (accept && (ptr_reg == IDX_W'(gi))) begin
          slot_reg[gi] <= beat_data;
        end
      end
      assign line_data[gi*BEAT_W +: BEAT_W] = slot_reg[gi];
    end
  endgenerate

  assign crit_valid = crit_valid_reg;
  assign crit_data  = crit_data_reg;
  assign last_err   = last_err_reg;

endmodule

// File: tb/tb_burst_line_buffer.sv
// Directed + randomized bench for burst_line_buffer; a slot-array model predicts every line.
module tb_burst_line_buffer;
  localparam int NB = 16;

  logic         clk = 1'b0;
  logic         rst, flush, start, beat_valid, beat_last, line_ready;
  logic [3:0]   start_idx;
  logic [31:0]  beat_data;
  logic         beat_ready, crit_valid, line_valid, busy, last_err;
  logic [31:0]  crit_data;
  logic [511:0] line_data;

  logic         b_start, b_beat_valid, b_beat_last, b_line_ready;
  logic [1:0]   b_start_idx;
  logic [63:0]  b_beat_data;
  logic         b_beat_ready, b_crit_valid, b_line_valid, b_busy, b_last_err;
  logic [63:0]  b_crit_data;
  logic [255:0] b_line_data;

  burst_line_buffer #(.BEAT_W(32), .LINE_W(512)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .start_idx(start_idx),
    .beat_data(beat_data), .beat_valid(beat_valid), .beat_last(beat_last),
    .beat_ready(beat_ready), .crit_valid(crit_valid), .crit_data(crit_data),
    .line_data(line_data), .line_valid(line_valid), .line_ready(line_ready),
    .busy(busy), .last_err(last_err)
  );

  burst_line_buffer #(.BEAT_W(64), .LINE_W(256)) dut_b (
    .clk(clk), .rst(rst), .flush(1'b0), .start(b_start), .start_idx(b_start_idx),
    .beat_data(b_beat_data), .beat_valid(b_beat_valid), .beat_last(b_beat_last),
    .beat_ready(b_beat_ready), .crit_valid(b_crit_valid), .crit_data(b_crit_data),
    .line_data(b_line_data), .line_valid(b_line_valid), .line_ready(b_line_ready),
    .busy(b_busy), .last_err(b_last_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the line as an array of slots plus the remembered critical word.
  logic [31:0] exp_slot [NB];
  logic [31:0] exp_crit;
  logic [31:0] vals [NB];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] exp_line();
    logic [511:0] v;
    for (int i = 0; i < NB; i++) v[i*32 +: 32] = exp_slot[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NB; i++) exp_slot[i] = '0;
  endtask

  task automatic start_burst(input int idx);
    start = 1'b1; start_idx = 4'(idx);
    step();
    start = 1'b0;
    model_clear();
    chk("start_busy", 512'(busy), 512'(1));
    chk("start_ready", 512'(beat_ready), 512'(1));
  endtask

  // Feed beats k0..k0+n-1 of a burst starting at slot idx; beat_last from mask.
  task automatic feed(input int idx, input int k0, input int n, input int max_gap,
                      input logic [15:0] mask);
    for (int k = k0; k < k0 + n; k++) begin
      if (max_gap > 0) begin
        repeat ($urandom_range(3, max_gap)) begin
          beat_valid = 1'b0; beat_data = $urandom;
          step();
        end
      end
      beat_valid = 1'b1; beat_data = vals[k]; beat_last = mask[k];
      step();
      beat_valid = 1'b0; beat_last = 1'b0;
      exp_slot[(idx + k) % NB] = vals[k];
      if (k == 0) exp_crit = vals[k];
      chk($sformatf("crit_valid_k%0d", k), 512'(crit_valid), 512'(k == 0));
      chk($sformatf("last_err_k%0d", k), 512'(last_err), 512'(mask[k] != (k == NB - 1)));
      chk($sformatf("line_valid_k%0d", k), 512'(line_valid), 512'(k == NB - 1));
    end
  endtask

  task automatic check_line(input string tag);
    chk({tag, "_line"}, line_data, exp_line());
    chk({tag, "_crit"}, 512'(crit_data), 512'(exp_crit));
    chk({tag, "_ready0"}, 512'(beat_ready), 512'(0));
  endtask

  task automatic release_line();
    line_ready = 1'b1;
    step();
    line_ready = 1'b0;
    chk("release_valid", 512'(line_valid), 512'(0));
    chk("release_busy", 512'(busy), 512'(0));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 512'(beat_ready), 512'(0));
    chk({tag, "_cv"}, 512'(crit_valid), 512'(0));
    chk({tag, "_cd"}, 512'(crit_data), 512'(0));
    chk({tag, "_line"}, line_data, 512'(0));
    chk({tag, "_lv"}, 512'(line_valid), 512'(0));
    chk({tag, "_busy"}, 512'(busy), 512'(0));
    chk({tag, "_err"}, 512'(last_err), 512'(0));
  endtask

  initial begin
    logic [511:0] snap;
    logic [255:0] b_exp;
    rst = 1'b1; flush = 0; start = 0; start_idx = 0; beat_data = 0;
    beat_valid = 0; beat_last = 0; line_ready = 0;
    b_start = 0; b_start_idx = 0; b_beat_data = 0; b_beat_valid = 0;
    b_beat_last = 0; b_line_ready = 0;
    exp_crit = '0;
    model_clear();
    @(negedge clk);
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_all_zero("idle");

    // Linear fill
    for (int i = 0; i < NB; i++) vals[i] = 32'h1000 + i;
    start_burst(0);
    feed(0, 0, NB, 0, 16'h8000);
    check_line("linear");
    chk("linear_slot15", 512'(line_data[15*32 +: 32]), 512'(32'h100F));
    release_line();

    // Wrap fill, critical word first
    for (int i = 0; i < NB; i++) vals[i] = 32'hA0 + i;
    start_burst(13);
    feed(13, 0, NB, 0, 16'h8000);
    check_line("wrap");
    chk("wrap_slot13", 512'(line_data[13*32 +: 32]), 512'(32'hA0));
    chk("wrap_slot0", 512'(line_data[0 +: 32]), 512'(32'hA3));
    chk("wrap_slot12", 512'(line_data[12*32 +: 32]), 512'(32'hAF));

    // Hold under backpressure with stray beats
    snap = exp_line();
    line_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      beat_valid = 1'b1; beat_data = $urandom;
      step();
      chk("hold_line", line_data, snap);
      chk("hold_valid", 512'(line_valid), 512'(1));
      chk("hold_ready", 512'(beat_ready), 512'(0));
    end
    beat_valid = 1'b0;
    release_line();

    // Random data with stall gaps
    for (int r = 0; r < 2; r++) begin
      int idx;
      idx = int'($urandom_range(0, NB - 1));
      for (int i = 0; i < NB; i++) vals[i] = $urandom;
      start_burst(idx);
      feed(idx, 0, NB, 5, 16'h8000);
      check_line("gap");
      release_line();
    end

    // Flush mid-burst, with a beat and a start in the flush cycle
    for (int i = 0; i < NB; i++) vals[i] = $urandom;
    start_burst(2);
    feed(2, 0, 7, 0, 16'h8000);
    flush = 1'b1; beat_valid = 1'b1; beat_data = 32'hDEAD_BEEF; start = 1'b1;
    step();
    flush = 1'b0; beat_valid = 1'b0; start = 1'b0;
    check_all_zero("flush");
    step();
    chk("flush_idle_busy", 512'(busy), 512'(0));
    for (int i = 0; i < NB; i++) vals[i] = $urandom;
    start_burst(4);
    feed(4, 0, NB, 0, 16'h8000);
    check_line("after_flush");

    // Back-to-back: start together with the handshake
    line_ready = 1'b1; start = 1'b1; start_idx = 4'd9;
    step();
    line_ready = 1'b0; start = 1'b0;
    model_clear();
    chk("b2b_busy", 512'(busy), 512'(1));
    chk("b2b_ready", 512'(beat_ready), 512'(1));
    chk("b2b_lv", 512'(line_valid), 512'(0));
    chk("b2b_cleared", line_data, 512'(0));
    for (int i = 0; i < NB; i++) vals[i] = $urandom;
    feed(9, 0, NB, 0, 16'h8000);
    check_line("b2b");
    release_line();

    // Misplaced beat_last markers
    for (int i = 0; i < NB; i++) vals[i] = $urandom;
    start_burst(7);
    feed(7, 0, NB, 0, 16'h0200);
    check_line("marker");
    release_line();

    // Reset mid-burst, then a clean burst
    for (int i = 0; i < NB; i++) vals[i] = $urandom;
    start_burst(1);
    feed(1, 0, 5, 0, 16'h8000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_crit = '0;
    check_all_zero("mid_rst");
    for (int i = 0; i < NB; i++) vals[i] = $urandom;
    start_burst(11);
    feed(11, 0, NB, 0, 16'h8000);
    check_line("after_rst");
    release_line();

    // 64-bit beats, 4-beat line
    b_start = 1'b1; b_start_idx = 2'd0;
    step();
    b_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b_beat_valid = 1'b1; b_beat_data = 64'h1000 + 64'(k); b_beat_last = (k == 3);
      step();
      b_beat_valid = 1'b0; b_beat_last = 1'b0;
      chk($sformatf("b_crit_valid_k%0d", k), 512'(b_crit_valid), 512'(k == 0));
      chk($sformatf("b_last_err_k%0d", k), 512'(b_last_err), 512'(0));
    end
    for (int i = 0; i < 4; i++) b_exp[i*64 +: 64] = 64'h1000 + 64'(i);
    chk("b_line_valid", 512'(b_line_valid), 512'(1));
    chk("b_line", 512'(b_line_data), 512'(b_exp));
    chk("b_crit", 512'(b_crit_data), 512'(64'h1000));
    b_line_ready = 1'b1;
    step();
    b_line_ready = 1'b0;
    chk("b_release_busy", 512'(b_busy), 512'(0));
    chk("b_release_ready", 512'(b_beat_ready), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
